// File: rtl/dc_pkg.sv
// Shared widths, metadata layout, request record and output-state encoding for
// the DRAM-cache tag comparator.
package dc_pkg;

  localparam int ID_W      = 16;
  localparam int TAG_W     = 32;
  localparam int INDEX_W   = 26;
  localparam int DATA_W    = 512;
  localparam int META_W    = 64;
  localparam int REQ_DEPTH = 4;

  // TAG_S word layout: {valid, dirty, tag[31:0], don't-care[29:0]}
  localparam int VALID_BIT = 63;
  localparam int DIRTY_BIT = 62;
  localparam int TAG_MSB   = 61;
  localparam int TAG_LSB   = 30;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               wr;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD_R = 2'd1,
    ST_HOLD_W = 2'd2,
    ST_HOLD_M = 2'd3
  } state_t;

endpackage

// File: rtl/dc_tag_comparator_if.sv
// Bundles the request, memory R, processor R, write-hit, miss and status
// signals of the tag comparator. slave = comparator side, master = its environment.
interface dc_tag_comparator_if;
  import dc_pkg::*;

  // Every channel uses valid/ready: a transfer happens on a cycle where both are
  // high; the sender holds valid and payload stable until then, and ready may
  // depend combinationally on valid.
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [ID_W-1:0]          req_id_i;
  logic [TAG_W-1:0]         req_tag_i;
  logic [INDEX_W-1:0]       req_index_i;
  logic                     req_wr_i;

  logic [ID_W-1:0]          m_rid_i;
  logic [META_W+DATA_W-1:0] m_rdata_i;
  logic                     m_rvalid_i;
  logic                     m_rready_o;

  logic [ID_W-1:0]          rid_o;
  logic [DATA_W-1:0]        rdata_o;
  logic                     rvalid_o;
  logic                     rready_i;

  logic [ID_W-1:0]          whit_id_o;
  logic [INDEX_W-1:0]       whit_index_o;
  logic                     whit_valid_o;
  logic                     whit_ready_i;

  logic [ID_W-1:0]          miss_id_o;
  logic                     miss_wr_o;
  logic [TAG_W-1:0]         miss_tag_o;
  logic [INDEX_W-1:0]       miss_index_o;
  logic                     miss_vdirty_o;
  logic [TAG_W-1:0]         miss_vtag_o;
  logic [DATA_W-1:0]        miss_vdata_o;
  logic                     miss_valid_o;
  logic                     miss_ready_i;

  logic                     id_err_o;
  logic [31:0]              hit_cnt_o;
  logic [31:0]              miss_cnt_o;
  state_t                   dbg_state_o;

  modport slave (
    input  req_valid_i, req_id_i, req_tag_i, req_index_i, req_wr_i,
    output req_ready_o,
    input  m_rid_i, m_rdata_i, m_rvalid_i,
    output m_rready_o,
    output rid_o, rdata_o, rvalid_o,
    input  rready_i,
    output whit_id_o, whit_index_o, whit_valid_o,
    input  whit_ready_i,
    output miss_id_o, miss_wr_o, miss_tag_o, miss_index_o, miss_vdirty_o,
    output miss_vtag_o, miss_vdata_o, miss_valid_o,
    input  miss_ready_i,
    output id_err_o, hit_cnt_o, miss_cnt_o, dbg_state_o
  );

  modport master (
    output req_valid_i, req_id_i, req_tag_i, req_index_i, req_wr_i,
    input  req_ready_o,
    output m_rid_i, m_rdata_i, m_rvalid_i,
    input  m_rready_o,
    input  rid_o, rdata_o, rvalid_o,
    output rready_i,
    input  whit_id_o, whit_index_o, whit_valid_o,
    output whit_ready_i,
    input  miss_id_o, miss_wr_o, miss_tag_o, miss_index_o, miss_vdirty_o,
    input  miss_vtag_o, miss_vdata_o, miss_valid_o,
    output miss_ready_i,
    input  id_err_o, hit_cnt_o, miss_cnt_o, dbg_state_o
  );

endinterface

// File: rtl/dc_sync_fifo.sv
// Registered-storage synchronous FIFO; DEPTH must be a power of two >= 2.
// A write while full is taken only if a read happens in the same cycle.
module dc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (do_wr && !do_rd) begin
        count_q <= count_q + CNT_ONE;
      end else if (do_rd && !do_wr) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/dc_tag_comparator.sv
// Pairs each DRAM-cache R beat with its queued request, decides hit/miss and
// hands the registered result to exactly one of R, write-hit or miss.
module dc_tag_comparator
  import dc_pkg::*;
(
  input logic               clk,
  input logic               rst,
  dc_tag_comparator_if.slave bus
);

  req_t                push_req;
  req_t                head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  logic [META_W-1:0]   meta;
  logic [DATA_W-1:0]   line;
  logic [TAG_LSB-1:0]  meta_unused;
  logic                meta_valid;
  logic                meta_dirty;
  logic [TAG_W-1:0]    meta_tag;
  logic                hit;

  state_t              state_q;
  state_t              state_d;
  logic                out_done;
  logic                m_rready;
  logic                accept;

  logic [ID_W-1:0]     rid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ID_W-1:0]     whit_id_q;
  logic [INDEX_W-1:0]  whit_index_q;
  logic [ID_W-1:0]     miss_id_q;
  logic                miss_wr_q;
  logic [TAG_W-1:0]    miss_tag_q;
  logic [INDEX_W-1:0]  miss_index_q;
  logic                miss_vdirty_q;
  logic [TAG_W-1:0]    miss_vtag_q;
  logic [DATA_W-1:0]   miss_vdata_q;
  logic                id_err_q;
  logic [31:0]         hit_cnt_q;
  logic [31:0]         miss_cnt_q;

  assign push_req = {bus.req_id_i, bus.req_tag_i, bus.req_index_i, bus.req_wr_i};
  assign push     = bus.req_valid_i && !fifo_full;
  assign pop      = accept;

  dc_sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_req),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign meta        = bus.m_rdata_i[META_W+DATA_W-1:DATA_W];
  assign line        = bus.m_rdata_i[DATA_W-1:0];
  assign meta_valid  = meta[VALID_BIT];
  assign meta_dirty  = meta[DIRTY_BIT];
  assign meta_tag    = meta[TAG_MSB:TAG_LSB];
  assign meta_unused = meta[TAG_LSB-1:0];
  assign hit         = meta_valid && (meta_tag == head.tag);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A new beat is taken while idle or in the same cycle the held result leaves,
  // which keeps one beat per cycle when the consumer is always ready.
  always_comb begin
    state_d  = state_q;
    out_done = 1'b0;
    case (state_q)
      ST_HOLD_R: out_done = bus.rready_i;
      ST_HOLD_W: out_done = bus.whit_ready_i;
      ST_HOLD_M: out_done = bus.miss_ready_i;
      default:   out_done = 1'b0;
    endcase
    m_rready = !fifo_empty && ((state_q == ST_IDLE) || out_done);
    accept   = bus.m_rvalid_i && m_rready;
    if (accept) begin
      if (!hit)         state_d = ST_HOLD_M;
      else if (head.wr) state_d = ST_HOLD_W;
      else              state_d = ST_HOLD_R;
    end else if (out_done) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rid_q         <= '0;
      rdata_q       <= '0;
      whit_id_q     <= '0;
      whit_index_q  <= '0;
      miss_id_q     <= '0;
      miss_wr_q     <= 1'b0;
      miss_tag_q    <= '0;
      miss_index_q  <= '0;
      miss_vdirty_q <= 1'b0;
      miss_vtag_q   <= '0;
      miss_vdata_q  <= '0;
    end else if (accept) begin
      if (hit && !head.wr) begin
        rid_q   <= head.id;
        rdata_q <= line;
      end
      if (hit && head.wr) begin
        whit_id_q    <= head.id;
        whit_index_q <= head.index;
      end
      if (!hit) begin
        miss_id_q     <= head.id;
        miss_wr_q     <= head.wr;
        miss_tag_q    <= head.tag;
        miss_index_q  <= head.index;
        miss_vdirty_q <= meta_valid && meta_dirty;
        miss_vtag_q   <= meta_tag;
        miss_vdata_q  <= line;
      end
    end
  end

  // The returned ID is only a consistency check; the head entry stays authoritative.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_err_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (bus.m_rid_i != head.id) id_err_q <= 1'b1;
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.req_ready_o   = !fifo_full;
  assign bus.m_rready_o    = m_rready;

  assign bus.rid_o         = rid_q;
  assign bus.rdata_o       = rdata_q;
  assign bus.rvalid_o      = (state_q == ST_HOLD_R);

  assign bus.whit_id_o     = whit_id_q;
  assign bus.whit_index_o  = whit_index_q;
  assign bus.whit_valid_o  = (state_q == ST_HOLD_W);

  assign bus.miss_id_o     = miss_id_q;
  assign bus.miss_wr_o     = miss_wr_q;
  assign bus.miss_tag_o    = miss_tag_q;
  assign bus.miss_index_o  = miss_index_q;
  assign bus.miss_vdirty_o = miss_vdirty_q;
  assign bus.miss_vtag_o   = miss_vtag_q;
  assign bus.miss_vdata_o  = miss_vdata_q;
  assign bus.miss_valid_o  = (state_q == ST_HOLD_M);

  assign bus.id_err_o      = id_err_q;
  assign bus.hit_cnt_o     = hit_cnt_q;
  assign bus.miss_cnt_o    = miss_cnt_q;
  assign bus.dbg_state_o   = state_q;

endmodule

// File: tb/tb_dc_tag_comparator.sv
// Bench for dc_tag_comparator: directed scenarios with literal expectations plus
// a random phase, all checked every cycle against a queue-based reference model.
module tb_dc_tag_comparator;
  import dc_pkg::*;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               wr;
  } mreq_t;

  typedef struct packed {
    logic [1:0]         kind;
    logic [ID_W-1:0]    id;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               wr;
    logic               vdirty;
    logic [TAG_W-1:0]   vtag;
    logic [DATA_W-1:0]  data;
  } mres_t;

  localparam int         RES_W  = $bits(mres_t);
  localparam logic [1:0] K_RD   = 2'd1;
  localparam logic [1:0] K_WR   = 2'd2;
  localparam logic [1:0] K_MISS = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dc_tag_comparator_if bus ();

  dc_tag_comparator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // ---------------- reference model state ----------------
  mreq_t             req_q[$];
  logic [RES_W-1:0]  exp_q[$];
  logic              exp_err  = 1'b0;
  logic [31:0]       exp_hit  = '0;
  logic [31:0]       exp_miss = '0;
  bit                model_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_line(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic out_ready(input logic [1:0] k);
    return (k == K_RD && bus.rready_i) || (k == K_WR && bus.whit_ready_i) ||
           (k == K_MISS && bus.miss_ready_i);
  endfunction

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [META_W-1:0] mk_meta(input logic v, input logic d, input logic [TAG_W-1:0] t);
    return {v, d, t, 30'($urandom)};
  endfunction

  // The result of a beat depends only on the oldest pending request and the
  // metadata word: hit when the slot is valid and its tag equals the request tag.
  always @(posedge clk) begin : model
    mreq_t             h;
    mres_t             r;
    mres_t             cur;
    logic [META_W-1:0] mt;
    logic              done;
    logic              mready;
    logic              acc;
    logic              psh;
    if (rst) begin
      req_q.delete();
      exp_q.delete();
      exp_err  = 1'b0;
      exp_hit  = '0;
      exp_miss = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      cur    = (exp_q.size() != 0) ? exp_q[0] : '0;
      done   = (exp_q.size() != 0) && out_ready(cur.kind);
      mready = (req_q.size() != 0) && ((exp_q.size() == 0) || done);
      acc    = bus.m_rvalid_i && mready;
      psh    = bus.req_valid_i && (req_q.size() < REQ_DEPTH);
      if (done) void'(exp_q.pop_front());
      if (acc) begin
        h  = req_q.pop_front();
        mt = bus.m_rdata_i[META_W+DATA_W-1:DATA_W];
        r  = '0;
        r.id    = h.id;
        r.tag   = h.tag;
        r.index = h.index;
        r.wr    = h.wr;
        r.data  = bus.m_rdata_i[DATA_W-1:0];
        if (mt[63] && (mt[61:30] == h.tag)) begin
          r.kind  = h.wr ? K_WR : K_RD;
          exp_hit = exp_hit + 1;
        end else begin
          r.kind   = K_MISS;
          r.vdirty = mt[63] & mt[62];
          r.vtag   = mt[61:30];
          exp_miss = exp_miss + 1;
        end
        if (bus.m_rid_i != h.id) exp_err = 1'b1;
        exp_q.push_back(r);
      end
      if (psh) begin
        h.id    = bus.req_id_i;
        h.tag   = bus.req_tag_i;
        h.index = bus.req_index_i;
        h.wr    = bus.req_wr_i;
        req_q.push_back(h);
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    mres_t e;
    logic  has;
    if (model_ok) begin
      has = (exp_q.size() != 0);
      e   = has ? exp_q[0] : '0;
      chk("req_ready", 32'(bus.req_ready_o), 32'(req_q.size() < REQ_DEPTH));
      chk("m_rready", 32'(bus.m_rready_o), 32'((req_q.size() != 0) && (!has || out_ready(e.kind))));
      chk("rvalid", 32'(bus.rvalid_o), 32'(has && e.kind == K_RD));
      chk("whit_valid", 32'(bus.whit_valid_o), 32'(has && e.kind == K_WR));
      chk("miss_valid", 32'(bus.miss_valid_o), 32'(has && e.kind == K_MISS));
      chk("id_err", 32'(bus.id_err_o), 32'(exp_err));
      chk("hit_cnt", bus.hit_cnt_o, exp_hit);
      chk("miss_cnt", bus.miss_cnt_o, exp_miss);
      if (has && e.kind == K_RD) begin
        chk("rid", 32'(bus.rid_o), 32'(e.id));
        chk_line("rdata", bus.rdata_o, e.data);
      end
      if (has && e.kind == K_WR) begin
        chk("whit_id", 32'(bus.whit_id_o), 32'(e.id));
        chk("whit_index", 32'(bus.whit_index_o), 32'(e.index));
      end
      if (has && e.kind == K_MISS) begin
        chk("miss_id", 32'(bus.miss_id_o), 32'(e.id));
        chk("miss_wr", 32'(bus.miss_wr_o), 32'(e.wr));
        chk("miss_tag", bus.miss_tag_o, e.tag);
        chk("miss_index", 32'(bus.miss_index_o), 32'(e.index));
        chk("miss_vdirty", 32'(bus.miss_vdirty_o), 32'(e.vdirty));
        chk("miss_vtag", bus.miss_vtag_o, e.vtag);
        chk_line("miss_vdata", bus.miss_vdata_o, e.data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i  = 1'b0;
    bus.req_id_i     = '0;
    bus.req_tag_i    = '0;
    bus.req_index_i  = '0;
    bus.req_wr_i     = 1'b0;
    bus.m_rvalid_i   = 1'b0;
    bus.m_rid_i      = '0;
    bus.m_rdata_i    = '0;
    bus.rready_i     = 1'b1;
    bus.whit_ready_i = 1'b1;
    bus.miss_ready_i = 1'b1;
  endtask

  task automatic push_req(input int id, input int tag, input int idx, input logic wr);
    bus.req_valid_i = 1'b1;
    bus.req_id_i    = ID_W'(id);
    bus.req_tag_i   = TAG_W'(tag);
    bus.req_index_i = INDEX_W'(idx);
    bus.req_wr_i    = wr;
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic send_beat(input int rid, input logic [META_W-1:0] mt, input logic [DATA_W-1:0] ln);
    int n;
    n = 0;
    bus.m_rvalid_i = 1'b1;
    bus.m_rid_i    = ID_W'(rid);
    bus.m_rdata_i  = {mt, ln};
    #1;
    while (!bus.m_rready_o && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: got no m_rready want m_rready within 50 cycles @%0t", $time);
    end
    tick();
    bus.m_rvalid_i = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [DATA_W-1:0] ones;
    logic [DATA_W-1:0] ln_a;
    ones = '1;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    chk("rst_whit_valid", 32'(bus.whit_valid_o), 32'd0);
    chk("rst_miss_valid", 32'(bus.miss_valid_o), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_m_rready", 32'(bus.m_rready_o), 32'd0);
    chk("rst_hit_cnt", bus.hit_cnt_o, 32'd0);
    chk("rst_miss_cnt", bus.miss_cnt_o, 32'd0);
    chk("rst_id_err", 32'(bus.id_err_o), 32'd0);
    chk_line("rst_rdata", bus.rdata_o, '0);
    chk_line("rst_vdata", bus.miss_vdata_o, '0);
    tick();

    // read hit
    push_req(1, 'hF, 1, 1'b0);
    send_beat(1, 64'hC000_0003_C000_0000, ones);
    @(negedge clk);
    chk("rh_rvalid", 32'(bus.rvalid_o), 32'd1);
    chk("rh_rid", 32'(bus.rid_o), 32'd1);
    chk_line("rh_rdata", bus.rdata_o, ones);
    chk("rh_hit_cnt", bus.hit_cnt_o, 32'd1);
    tick();

    // write miss, clean victim (tag 5)
    push_req(2, 'hF, 1, 1'b1);
    send_beat(2, 64'h8000_0001_4000_0000, rand_line());
    @(negedge clk);
    chk("wm_miss_valid", 32'(bus.miss_valid_o), 32'd1);
    chk("wm_miss_wr", 32'(bus.miss_wr_o), 32'd1);
    chk("wm_vdirty", 32'(bus.miss_vdirty_o), 32'd0);
    chk("wm_vtag", bus.miss_vtag_o, 32'd5);
    chk("wm_miss_cnt", bus.miss_cnt_o, 32'd1);
    tick();

    // dirty eviction held by a stalled miss handler while the next beat waits
    bus.miss_ready_i = 1'b0;
    ln_a = rand_line();
    push_req(4, 'hF, 2, 1'b0);
    push_req(5, 'h7, 3, 1'b0);
    send_beat(4, 64'hC000_0001_4000_0000, ln_a);
    bus.m_rvalid_i = 1'b1;
    bus.m_rid_i    = 16'd5;
    bus.m_rdata_i  = {64'hC000_0001_C000_0000, ones};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("de_miss_valid", 32'(bus.miss_valid_o), 32'd1);
      chk("de_vdirty", 32'(bus.miss_vdirty_o), 32'd1);
      chk("de_vtag", bus.miss_vtag_o, 32'd5);
      chk("de_miss_id", 32'(bus.miss_id_o), 32'd4);
      chk_line("de_vdata", bus.miss_vdata_o, ln_a);
      chk("de_m_rready", 32'(bus.m_rready_o), 32'd0);
      tick();
    end
    bus.miss_ready_i = 1'b1;
    tick();
    bus.m_rvalid_i = 1'b0;
    @(negedge clk);
    chk("de_next_rvalid", 32'(bus.rvalid_o), 32'd1);
    chk("de_next_rid", 32'(bus.rid_o), 32'd5);
    chk("de_miss_gone", 32'(bus.miss_valid_o), 32'd0);
    tick();

    // back-to-back: fill the FIFO, then one hitting beat per cycle
    for (int k = 0; k < 4; k++) push_req(10 + k, 'h20 + k, k, 1'b0);
    @(negedge clk);
    chk("bb_full_ready", 32'(bus.req_ready_o), 32'd0);
    tick();
    bus.m_rvalid_i = 1'b1;
    bus.m_rid_i    = 16'd10;
    bus.m_rdata_i  = {mk_meta(1'b1, 1'b0, 32'h20), rand_line()};
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) begin
        bus.m_rid_i   = ID_W'(11 + k);
        bus.m_rdata_i = {mk_meta(1'b1, 1'b0, TAG_W'(32'h21 + k)), rand_line()};
      end else begin
        bus.m_rvalid_i = 1'b0;
      end
      @(negedge clk);
      chk("bb_rvalid", 32'(bus.rvalid_o), 32'd1);
      chk("bb_rid", 32'(bus.rid_o), 32'(10 + k));
      if (k == 0) chk("bb_ready_after_pop", 32'(bus.req_ready_o), 32'd1);
    end
    chk("bb_hit_cnt", bus.hit_cnt_o, 32'd6);
    chk("bb_miss_cnt", bus.miss_cnt_o, 32'd2);
    chk("bb_id_err", 32'(bus.id_err_o), 32'd0);
    tick();

    // ID mismatch: head id 3, returned id 7
    push_req(3, 'h9, 4, 1'b0);
    send_beat(7, 64'h8000_0002_4000_0000, rand_line());
    @(negedge clk);
    chk("idm_err", 32'(bus.id_err_o), 32'd1);
    chk("idm_rvalid", 32'(bus.rvalid_o), 32'd1);
    chk("idm_rid", 32'(bus.rid_o), 32'd3);
    repeat (3) tick();
    @(negedge clk);
    chk("idm_sticky", 32'(bus.id_err_o), 32'd1);
    tick();

    // reset with a held result and two pending requests
    bus.rready_i = 1'b0;
    push_req(20, 1, 5, 1'b0);
    push_req(21, 1, 6, 1'b0);
    push_req(22, 1, 7, 1'b0);
    send_beat(20, 64'h8000_0000_4000_0000, rand_line());
    bus.m_rvalid_i = 1'b1;
    bus.m_rid_i    = 16'd21;
    bus.m_rdata_i  = {64'h8000_0000_4000_0000, ones};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_rvalid", 32'(bus.rvalid_o), 32'd0);
    chk("mr_whit_valid", 32'(bus.whit_valid_o), 32'd0);
    chk("mr_miss_valid", 32'(bus.miss_valid_o), 32'd0);
    chk("mr_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("mr_m_rready", 32'(bus.m_rready_o), 32'd0);
    chk("mr_hit_cnt", bus.hit_cnt_o, 32'd0);
    chk("mr_miss_cnt", bus.miss_cnt_o, 32'd0);
    chk("mr_id_err", 32'(bus.id_err_o), 32'd0);
    chk_line("mr_rdata", bus.rdata_o, '0);
    tick();
    @(negedge clk);
    chk("mr_no_accept_cnt", bus.hit_cnt_o, 32'd0);
    chk("mr_no_accept_valid", 32'(bus.rvalid_o), 32'd0);
    idle_inputs();
    tick();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid_i  = ($urandom_range(0, 2) != 0);
      bus.req_id_i     = ID_W'($urandom);
      bus.req_tag_i    = TAG_W'($urandom_range(0, 3));
      bus.req_index_i  = INDEX_W'($urandom);
      bus.req_wr_i     = 1'($urandom_range(0, 1));
      bus.m_rvalid_i   = ($urandom_range(0, 3) != 0);
      if (req_q.size() != 0 && $urandom_range(0, 99) != 0) bus.m_rid_i = req_q[0].id;
      else bus.m_rid_i = ID_W'($urandom);
      bus.m_rdata_i    = {mk_meta(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                                  TAG_W'($urandom_range(0, 3))), rand_line()};
      bus.rready_i     = ($urandom_range(0, 3) != 0);
      bus.whit_ready_i = ($urandom_range(0, 3) != 0);
      bus.miss_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_inputs();
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
